// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ reporters. It sends each granted
// message as one frame (SOF, requester ID, payload, checksum) and then holds an idle gap.
module uart_tx_frame_arbiter #(
    parameter int         NUM_REQ   = 4,
    parameter int         MSG_BYTES = 2,
    parameter logic [7:0] SOF_BYTE  = 8'hA5,
    parameter int         GAP_CLKS  = 16
) (
    input  logic                           i_Clock,
    input  logic                           i_Rst_n,
    input  logic [NUM_REQ-1:0]             i_Req,
    input  logic [NUM_REQ*MSG_BYTES*8-1:0] i_Msg,
    output logic [NUM_REQ-1:0]             o_Ack,
    output logic                           o_Busy,
    output logic                           o_Tx_DV,
    output logic [7:0]                     o_Tx_Byte,
    input  logic                           i_Tx_Active,
    input  logic                           i_Tx_Done,
    output logic [2:0]                     o_Dbg_State
);
    localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FRAME_LEN = MSG_BYTES + 3;
    localparam int IW        = $clog2(FRAME_LEN);
    localparam int GW        = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t                             state, state_d;
    logic [PW-1:0]                      ptr, grant_q, pick, cand_idx;
    logic                               any_req;
    logic [NUM_REQ-1:0][MSG_BYTES-1:0][7:0] msg_arr;
    logic [MSG_BYTES-1:0][7:0]          msg_q;
    logic [7:0]                         csum_q, load_sum, frame_byte;
    logic [IW-1:0]                      idx;
    logic [GW-1:0]                      gap_cnt;
    logic                               done_q, done_rise, line_idle, last_byte;

    assign msg_arr   = i_Msg;
    assign line_idle = ~i_Tx_Active & ~i_Tx_Done;
    assign done_rise = i_Tx_Done & ~done_q;
    assign last_byte = (idx == IW'(FRAME_LEN - 1));

    // First requester at or after the pointer, wrapping.
    always_comb begin
        pick     = '0;
        any_req  = 1'b0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (!any_req && i_Req[cand_idx]) begin
                any_req = 1'b1;
                pick    = cand_idx;
            end
        end
    end

    always_comb begin
        load_sum = 8'(grant_q);
        for (int j = 0; j < MSG_BYTES; j++) begin
            load_sum = load_sum + msg_arr[grant_q][j];
        end
    end

    always_comb begin
        frame_byte = csum_q;
        if (idx == '0) begin
            frame_byte = SOF_BYTE;
        end else if (idx == IW'(1)) begin
            frame_byte = 8'(grant_q);
        end else begin
            for (int j = 0; j < MSG_BYTES; j++) begin
                if (idx == IW'(j + 2)) frame_byte = msg_q[j];
            end
        end
    end

    // Byte handshake: o_Tx_DV is a one-cycle strobe issued only while the line is idle
    // (not active, not done); the byte is held until the rising edge of i_Tx_Done is seen.
    always_comb begin
        state_d = state;
        o_Tx_DV = 1'b0;
        case (state)
            S_IDLE: if (any_req) state_d = S_LOAD;
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                if (line_idle) begin
                    o_Tx_DV = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_rise) begin
                    if (!last_byte)         state_d = S_SEND;
                    else if (GAP_CLKS == 0) state_d = S_IDLE;
                    else                    state_d = S_GAP;
                end
            end
            S_GAP:   if (gap_cnt == GW'(GAP_CLKS - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_Ack = '0;
        if (state == S_LOAD) o_Ack[grant_q] = 1'b1;
    end

    assign o_Busy      = (state == S_SEND) || (state == S_WAIT) || (state == S_GAP);
    assign o_Tx_Byte   = ((state == S_SEND) || (state == S_WAIT)) ? frame_byte : 8'h00;
    assign o_Dbg_State = state;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= S_IDLE;
            ptr     <= '0;
            grant_q <= '0;
            msg_q   <= '0;
            csum_q  <= '0;
            idx     <= '0;
            gap_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= i_Tx_Done;
            case (state)
                S_IDLE: if (any_req) grant_q <= pick;
                S_LOAD: begin
                    msg_q  <= msg_arr[grant_q];
                    csum_q <= load_sum;
                    ptr    <= (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    idx    <= '0;
                end
                S_WAIT: if (done_rise && !last_byte) idx <= idx + 1'b1;
                S_GAP:  gap_cnt <= (state_d == S_GAP) ? gap_cnt + 1'b1 : '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Bench for uart_tx_frame_arbiter: a behavioural uart_tx responder, a byte scoreboard and a
// round-robin reference arbiter drive randomized frames through the arbiter.
module tb_uart_tx_frame_arbiter;
    localparam int         NUM_REQ   = 4;
    localparam int         MSG_BYTES = 2;
    localparam logic [7:0] SOF       = 8'hA5;
    localparam int         GAP_CLKS  = 16;
    localparam int         MW        = NUM_REQ * MSG_BYTES * 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_REQ-1:0] req = '0;
    logic [MW-1:0]     msg = '0;
    logic [NUM_REQ-1:0] ack;
    logic              busy, tx_dv;
    logic [7:0]        tx_byte;
    logic              tx_active = 1'b0;
    logic              tx_done = 1'b0;
    logic [2:0]        dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];
    int ref_ptr = 0;
    int dv_count = 0;
    int busy_min = 2, busy_max = 6;
    int done_min = 1, done_max = 2;
    bit hold_valid = 0;
    logic [7:0] held_byte = 8'h00;

    uart_tx_frame_arbiter #(
        .NUM_REQ(NUM_REQ), .MSG_BYTES(MSG_BYTES), .SOF_BYTE(SOF), .GAP_CLKS(GAP_CLKS)
    ) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Req(req), .i_Msg(msg), .o_Ack(ack),
        .o_Busy(busy), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Active(tx_active),
        .i_Tx_Done(tx_done), .o_Dbg_State(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- uart_tx responder + byte scoreboard (never reset, like the real one) ----
    initial begin : uart_model
        int act_cnt, done_cnt;
        logic dv_s;
        logic [7:0] byte_s, exp_b;
        act_cnt = 0;
        done_cnt = 0;
        forever begin
            @(negedge clk);
            dv_s = tx_dv;
            byte_s = tx_byte;
            if (tx_active && hold_valid && rst_n) begin
                tests_run++;
                if (tx_byte !== held_byte) begin
                    tests_failed++;
                    $display("FAIL byte_hold: got %h want %h", tx_byte, held_byte);
                end
            end
            if (dv_s === 1'b1) begin
                dv_count++;
                tests_run++;
                if (tx_active !== 1'b0 || tx_done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL dv_line_idle: active=%b done=%b want 0 0", tx_active, tx_done);
                end
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL dv_unexpected: got byte %h want no DV", byte_s);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (byte_s !== exp_b) begin
                        tests_failed++;
                        $display("FAIL frame_byte: got %h want %h", byte_s, exp_b);
                    end
                end
                held_byte = byte_s;
                hold_valid = 1;
            end
            @(posedge clk);
            #1;
            if (dv_s === 1'b1) begin
                tx_active = 1'b1;
                act_cnt = $urandom_range(busy_max, busy_min);
            end else if (tx_active) begin
                if (act_cnt > 0) act_cnt--;
                else begin
                    tx_active = 1'b0;
                    tx_done = 1'b1;
                    hold_valid = 0;
                    done_cnt = $urandom_range(done_max, done_min) - 1;
                end
            end else if (tx_done) begin
                if (done_cnt > 0) done_cnt--;
                else tx_done = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int ref_pick(input logic [NUM_REQ-1:0] r);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[(ref_ptr + i) % NUM_REQ]) return (ref_ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic void push_frame(input int id, input logic [MW-1:0] m);
        int sum;
        logic [7:0] b;
        exp_q.push_back(SOF);
        exp_q.push_back(8'(id));
        sum = id;
        for (int j = 0; j < MSG_BYTES; j++) begin
            b = m[(id * MSG_BYTES + j) * 8 +: 8];
            exp_q.push_back(b);
            sum = sum + int'(b);
        end
        exp_q.push_back(8'(sum % 256));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ack(output logic [NUM_REQ-1:0] seen, output logic busy_seen, output bit ok);
        ok = 0;
        seen = '0;
        busy_seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (ack !== '0) begin
                seen = ack;
                busy_seen = busy;
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_frame_end(output bit ok);
        ok = 0;
        @(negedge clk);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ack !== '0 || busy !== 1'b0 || tx_dv !== 1'b0 || tx_byte !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: ack=%b busy=%b dv=%b byte=%h want all zero",
                     ack, busy, tx_dv, tx_byte);
        end
        rst_n = 1'b1;
        ref_ptr = 0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ack !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_req: ack=%b busy=%b want 0 0", ack, busy);
        end
    endtask

    task automatic test_single;
        logic [NUM_REQ-1:0] seen;
        logic bz, prev;
        bit ok;
        int base, rises, gap;
        msg = {$urandom, $urandom};
        msg[(2 * MSG_BYTES + 0) * 8 +: 8] = 8'h12;
        msg[(2 * MSG_BYTES + 1) * 8 +: 8] = 8'h34;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'h12);
        exp_q.push_back(8'h34); exp_q.push_back(8'h48);
        base = dv_count;
        req = 4'b0100;
        wait_ack(seen, bz, ok);
        tests_run++;
        if (!ok || seen !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_ack: got %b want 0100", seen);
        end
        ref_ptr = 3;
        prev = tx_done;
        @(negedge clk);
        req = '0;
        tests_run++;
        if (ack !== '0) begin
            tests_failed++;
            $display("FAIL ack_pulse_width: got %b want 0000", ack);
        end
        rises = 0;
        for (int c = 0; c < 600 && rises < 5; c++) begin
            if (tx_done && !prev) rises++;
            prev = tx_done;
            if (rises < 5) @(negedge clk);
        end
        tests_run++;
        if (rises != 5) begin
            tests_failed++;
            $display("FAIL single_done_count: got %0d want 5", rises);
        end
        gap = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy === 1'b1) gap++;
            else break;
        end
        tests_run++;
        if (gap != GAP_CLKS) begin
            tests_failed++;
            $display("FAIL gap_length: got %0d want %0d", gap, GAP_CLKS);
        end
        tests_run++;
        if (dv_count - base != 5 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL single_dv_count: got %0d left %0d want 5 left 0",
                     dv_count - base, exp_q.size());
        end
    endtask

    task automatic test_contention;
        logic [NUM_REQ-1:0] seen;
        logic bz;
        bit ok;
        int k, base;
        req = 4'b1111;
        msg = {$urandom, $urandom};
        for (int f = 0; f < 6; f++) begin
            k = ref_pick(req);
            push_frame(k, msg);
            base = dv_count;
            wait_ack(seen, bz, ok);
            tests_run++;
            if (!ok || seen !== 4'(1 << k) || bz !== 1'b0) begin
                tests_failed++;
                $display("FAIL contention_grant[%0d]: ack=%b busy=%b want %b 0",
                         f, seen, bz, 4'(1 << k));
            end
            ref_ptr = (k + 1) % NUM_REQ;
            @(negedge clk);
            msg = {$urandom, $urandom};
            wait_frame_end(ok);
            tests_run++;
            if (!ok || dv_count - base != 5 || exp_q.size() != 0) begin
                tests_failed++;
                $display("FAIL contention_frame[%0d]: dv=%0d left=%0d want 5 0",
                         f, dv_count - base, exp_q.size());
            end
        end
        req = '0;
    endtask

    task automatic test_checksum_wrap;
        logic [NUM_REQ-1:0] seen;
        logic bz;
        bit ok;
        msg = {$urandom, $urandom};
        msg[(3 * MSG_BYTES) * 8 +: 16] = 16'hFFFF;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h03); exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
        req = 4'b1000;
        wait_ack(seen, bz, ok);
        tests_run++;
        if (!ok || seen !== 4'b1000) begin
            tests_failed++;
            $display("FAIL wrap_ack: got %b want 1000", seen);
        end
        ref_ptr = 0;
        @(negedge clk);
        req = '0;
        wait_frame_end(ok);
        tests_run++;
        if (!ok || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wrap_frame: left %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_done_two;
        logic [NUM_REQ-1:0] seen, mask;
        logic bz;
        bit ok;
        int k, base;
        done_min = 2;
        done_max = 2;
        for (int f = 0; f < 4; f++) begin
            mask = 4'($urandom_range(15, 1));
            msg = {$urandom, $urandom};
            k = ref_pick(mask);
            push_frame(k, msg);
            base = dv_count;
            req = mask;
            wait_ack(seen, bz, ok);
            tests_run++;
            if (!ok || seen !== 4'(1 << k)) begin
                tests_failed++;
                $display("FAIL done2_grant[%0d]: got %b want %b", f, seen, 4'(1 << k));
            end
            ref_ptr = (k + 1) % NUM_REQ;
            @(negedge clk);
            req = '0;
            msg = {$urandom, $urandom};
            wait_frame_end(ok);
            tests_run++;
            if (!ok || dv_count - base != 5 || exp_q.size() != 0) begin
                tests_failed++;
                $display("FAIL done2_frame[%0d]: dv=%0d left=%0d want 5 0",
                         f, dv_count - base, exp_q.size());
            end
        end
        done_min = 1;
        done_max = 2;
    endtask

    task automatic test_late_payload;
        logic [NUM_REQ-1:0] seen;
        logic bz;
        bit ok;
        msg = {$urandom, $urandom};
        push_frame(1, msg);
        req = 4'b0010;
        wait_ack(seen, bz, ok);
        tests_run++;
        if (!ok || seen !== 4'b0010) begin
            tests_failed++;
            $display("FAIL late_ack: got %b want 0010", seen);
        end
        ref_ptr = 2;
        @(negedge clk);
        msg = ~msg;
        req = '0;
        wait_frame_end(ok);
        tests_run++;
        if (!ok || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL late_frame: left %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [NUM_REQ-1:0] seen;
        logic bz;
        bit ok, hit;
        int base;
        busy_min = 12;
        busy_max = 12;
        msg = {$urandom, $urandom};
        push_frame(ref_pick(4'b0100), msg);
        base = dv_count;
        req = 4'b0100;
        wait_ack(seen, bz, ok);
        @(negedge clk);
        req = '0;
        hit = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (dv_count - base >= 3 && tx_active === 1'b1) begin
                hit = 1;
                break;
            end
        end
        tests_run++;
        if (!hit) begin
            tests_failed++;
            $display("FAIL reset_mid_reach: dv=%0d want 3", dv_count - base);
        end
        hold_valid = 0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ack !== '0 || busy !== 1'b0 || tx_dv !== 1'b0 || tx_byte !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: ack=%b busy=%b dv=%b byte=%h want all zero",
                     ack, busy, tx_dv, tx_byte);
        end
        exp_q.delete();
        ref_ptr = 0;
        busy_min = 2;
        busy_max = 6;
        msg = {$urandom, $urandom};
        push_frame(0, msg);
        req = 4'b0001;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = dv_count;
        wait_ack(seen, bz, ok);
        tests_run++;
        if (!ok || seen !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_mid_ack: got %b want 0001", seen);
        end
        ref_ptr = 1;
        @(negedge clk);
        req = '0;
        wait_frame_end(ok);
        tests_run++;
        if (!ok || dv_count - base != 5 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_frame: dv=%0d left=%0d want 5 0", dv_count - base, exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset;
        test_single;
        test_contention;
        test_checksum_wrap;
        test_done_two;
        test_late_payload;
        test_reset_mid_frame;
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        tests_failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_frame_arbiter.md
Name: uart_tx_frame_arbiter

Overview:
- Shares one uart_tx transmitter between NUM_REQ requesters (e.g. paddle, ball and score reporters) using round-robin arbitration.
- Each granted requester's message is latched and sent as one frame: SOF byte, requester ID byte, MSG_BYTES payload bytes, then an 8-bit checksum byte.
- Drives the transmitter's byte handshake (data-valid / byte / done) and enforces an idle gap between frames.
- Sits between the game-logic reporters and the uart_tx instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MSG_BYTES, 2, payload bytes per frame (1..8).
- SOF_BYTE, 8'hA5, start-of-frame byte value.
- GAP_CLKS, 16, idle clocks after a frame's last byte completes before the next arbitration (0 allowed).

Ports:
- i_Clock  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Req  in  NUM_REQ  per-requester request level.
- i_Msg  in  NUM_REQ*MSG_BYTES*8  payloads; requester k byte j at bits [(k*MSG_BYTES+j)*8 +: 8]; byte 0 is sent first.
- o_Ack  out  NUM_REQ  one-hot, one-cycle pulse: requester's message latched.
- o_Busy  out  1  high from ack until gap end.
- o_Tx_DV  out  1  one-cycle byte-valid pulse to uart_tx.
- o_Tx_Byte  out  8  byte to uart_tx; held stable from the DV cycle until byte done.
- i_Tx_Active  in  1  uart_tx active flag.
- i_Tx_Done  in  1  uart_tx done flag (high ≥1 cycle, typically 2, per byte).

Behaviour:
- Reset (async assert, sync release): o_Ack=0, o_Busy=0, o_Tx_DV=0, o_Tx_Byte=0, state=IDLE, round-robin pointer=0, latched data cleared.
- Reset mid-frame aborts the frame silently; no ack is replayed. uart_tx has no reset, so first DV after reset still obeys the line-idle rule below.
- Line idle is defined as i_Tx_Active=0 and i_Tx_Done=0. o_Tx_DV is never asserted unless line idle holds in that cycle.
- IDLE: if any i_Req is high, pick the first requester at or after pointer (wrapping modulo NUM_REQ) → LOAD. Otherwise stay.
- LOAD (1 cycle):
  - Pulse o_Ack[k].
  - Latch requester k's payload and ID = k (zero-extended to 8 bits).
  - Checksum = (ID + sum of payload bytes) mod 256.
  - Pointer ← (k+1) mod NUM_REQ; o_Busy ← 1; byte index ← 0 → SEND.
- Requester contract: hold i_Req and i_Msg stable until o_Ack. i_Req may drop after ack. i_Msg changes after ack do not affect the frame.
- i_Req dropping before grant is legal; the request is simply not seen.
- SEND: wait for line idle, then drive o_Tx_Byte = frame byte[index] and pulse o_Tx_DV for exactly 1 cycle → WAIT.
  - Frame order: SOF_BYTE, ID, payload[0..MSG_BYTES-1], checksum.
  - Frame length = MSG_BYTES+3.
- WAIT: on rising edge of i_Tx_Done (i_Tx_Done=1 and previous cycle 0):
  - If index < MSG_BYTES+2: index+1 → SEND.
  - Else: → GAP.
  - A multi-cycle done high counts once.
- GAP: count GAP_CLKS cycles (0 means skip); then o_Busy ← 0 → IDLE.
  - Arbitration can grant in the cycle after o_Busy falls.
  - Requests arriving during a frame wait; no preemption.
- Simultaneous requests: round-robin order starting at pointer; every continuously requesting requester is served within NUM_REQ frames.
- At most one frame in flight; o_Ack is never asserted while o_Busy=1 before LOAD.

Test Plan:
- Single request: NUM_REQ=4, MSG_BYTES=2, i_Req=4'b0100, payload 8'h12,8'h34 → o_Ack=4'b0100 for 1 cycle; uart_tx serial bytes A5,02,12,34,48; exactly 5 o_Tx_DV pulses; o_Busy low GAP_CLKS cycles after 5th done.
- Contention: i_Req=4'b1111 held after each ack → grant order 0,1,2,3,0; IDs 00,01,02,03,00; pointer wraps.
- Checksum wrap: requester 3, payload FF,FF → checksum (03+FF+FF) mod 256 = 8'h01.
- Done handling: uart_tx done high 2 cycles per byte → no byte skipped or duplicated; each DV occurs only with i_Tx_Active=0 and i_Tx_Done=0.
- Reset mid-frame: assert i_Rst_n=0 during payload byte 0 while uart_tx is still active → outputs zero immediately. After release with i_Req=4'b0001 → next DV waits until uart_tx finishes the old byte and done clears; new frame starts with A5,00.
- Late payload change: change i_Msg the cycle after ack → transmitted payload equals the latched values.
